// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder (I/S/B/R formats) feeding a 2-entry output FIFO with byte addresses.
// Optional macro INSTR_ENCODER_IMM_CHECK_EN flags out-of-range or misaligned immediates on out_err.
module instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    logic        imm_i_bad_s;
    logic        imm_b_bad_s;
    logic [31:0] enc_instr_s;
    logic        enc_err_s;
    logic        push_s;
    logic        pop_s;

    // The head entry lives directly in the output registers; the skid entry is the second slot.
    logic        skid_valid_r;
    logic [31:0] skid_instr_r;
    logic        skid_err_r;

    logic              head_v_s;
    logic [31:0]       head_i_s;
    logic              head_e_s;
    logic              skid_v_s;
    logic [31:0]       skid_i_s;
    logic              skid_e_s;
    logic [ADDR_W-1:0] addr_s;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    // 12-bit signed range for I/S; 13-bit signed, even-only range for B
    assign imm_i_bad_s = !((imm[31:11] == {21{1'b0}}) || (imm[31:11] == {21{1'b1}}));
    assign imm_b_bad_s = !((imm[31:12] == {20{1'b0}}) || (imm[31:12] == {20{1'b1}})) || imm[0];
`else
    logic unused_imm_s;
    assign unused_imm_s = ^imm[31:13];
    assign imm_i_bad_s  = 1'b0;
    assign imm_b_bad_s  = 1'b0;
`endif

    assign push_s = in_valid & in_ready;
    assign pop_s  = out_valid & out_ready;

    // Pack the field bundle into an instruction word for the selected format.
    always_comb begin
        enc_instr_s = NOP_WORD;
        enc_err_s   = 1'b1;
        case (op_sel)
            3'd0: begin
                enc_instr_s = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
                enc_err_s   = imm_i_bad_s;
            end
            3'd1: begin
                enc_instr_s = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
                enc_err_s   = imm_i_bad_s;
            end
            3'd2: begin
                enc_instr_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
                enc_err_s   = imm_i_bad_s;
            end
            3'd3: begin
                enc_instr_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
                enc_err_s   = imm_b_bad_s;
            end
            3'd4: begin
                enc_instr_s = {funct7, rs2, rs1, funct3, rd, OPC_OP};
                enc_err_s   = 1'b0;
            end
            default: begin
                enc_instr_s = NOP_WORD;
                enc_err_s   = 1'b1;
            end
        endcase
    end

    // FIFO next state: pop shifts skid into head, then a push fills the first free slot.
    always_comb begin
        head_v_s = out_valid;
        head_i_s = out_instr;
        head_e_s = out_err;
        skid_v_s = skid_valid_r;
        skid_i_s = skid_instr_r;
        skid_e_s = skid_err_r;
        if (pop_s) begin
            head_v_s = skid_valid_r;
            head_i_s = skid_instr_r;
            head_e_s = skid_err_r;
            skid_v_s = 1'b0;
        end else begin
            head_v_s = out_valid;
        end
        if (push_s && !head_v_s) begin
            head_v_s = 1'b1;
            head_i_s = enc_instr_s;
            head_e_s = enc_err_s;
        end else if (push_s) begin
            skid_v_s = 1'b1;
            skid_i_s = enc_instr_s;
            skid_e_s = enc_err_s;
        end else begin
            skid_v_s = skid_v_s;
        end
        addr_s = pop_s ? (out_addr + ADDR_W'(3'd4)) : out_addr;
    end

    // State and output registers; in_ready is derived from the next occupancy so it never sees out_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_instr    <= 32'h0000_0000;
            out_err      <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_instr_r <= 32'h0000_0000;
            skid_err_r   <= 1'b0;
            out_addr     <= BASE_ADDR;
            in_ready     <= 1'b1;
        end else begin
            out_valid    <= head_v_s;
            out_instr    <= head_i_s;
            out_err      <= head_e_s;
            skid_valid_r <= skid_v_s;
            skid_instr_r <= skid_i_s;
            skid_err_r   <= skid_e_s;
            out_addr     <= addr_s;
            in_ready     <= !(head_v_s && skid_v_s);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued on input handshake, checked at the FIFO head.
module tb_instr_encoder;

    localparam int AW = 4;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] ei;
        logic        ee;
    } stim_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op_sel = 3'd0;
    logic [4:0]    rd = 5'd0;
    logic [4:0]    rs1 = 5'd0;
    logic [4:0]    rs2 = 5'd0;
    logic [2:0]    funct3 = 3'd0;
    logic [6:0]    funct7 = 7'd0;
    logic [31:0]   imm = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err;

    stim_t         stim_q[$];
    stim_t         sb[$];
    logic [AW-1:0] exp_addr = '0;
    logic          ordy = 1'b0;
    logic          rnd_ready = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(4'd0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference encoder built by shifting fields into place.
    function automatic stim_t model(input stim_t s);
        stim_t r = s;
        int    v = int'(s.imm);
        logic [31:0] m;
        logic  bad_i = 1'b0;
        logic  bad_b = 1'b0;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
        bad_i = (v < -2048) || (v > 2047);
        bad_b = (v < -4096) || (v > 4094) || s.imm[0];
`endif
        m = (32'(s.rs1) << 15) | (32'(s.f3) << 12);
        case (s.op)
            3'd0, 3'd1: begin
                r.ei = ((s.imm & 32'hFFF) << 20) | m | (32'(s.rd) << 7) | (s.op == 3'd0 ? 32'h03 : 32'h13);
                r.ee = bad_i;
            end
            3'd2: begin
                r.ei = (((s.imm >> 5) & 32'h7F) << 25) | (32'(s.rs2) << 20) | m | ((s.imm & 32'h1F) << 7) | 32'h23;
                r.ee = bad_i;
            end
            3'd3: begin
                r.ei = (((s.imm >> 12) & 32'h1) << 31) | (((s.imm >> 5) & 32'h3F) << 25) | (32'(s.rs2) << 20) | m
                     | (((s.imm >> 1) & 32'hF) << 8) | (((s.imm >> 11) & 32'h1) << 7) | 32'h63;
                r.ee = bad_b;
            end
            3'd4: begin
                r.ei = (32'(s.f7) << 25) | (32'(s.rs2) << 20) | m | (32'(s.rd) << 7) | 32'h33;
                r.ee = 1'b0;
            end
            default: begin
                r.ei = 32'h13;
                r.ee = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic add(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                       input logic [31:0] ei, input logic ee);
        stim_t s;
        s.op = op; s.rd = d; s.rs1 = s1; s.rs2 = s2; s.f3 = f3; s.f7 = f7; s.imm = im;
        s.ei = ei; s.ee = ee;
        stim_q.push_back(s);
    endtask

    // One cycle: drive at negedge, sample 1ns later, the handshakes take effect at the next posedge.
    task automatic step();
        @(negedge clk);
        if (stim_q.size() != 0) begin
            in_valid = 1'b1;
            op_sel = stim_q[0].op; rd = stim_q[0].rd; rs1 = stim_q[0].rs1; rs2 = stim_q[0].rs2;
            funct3 = stim_q[0].f3; funct7 = stim_q[0].f7; imm = stim_q[0].imm;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ordy;
        #1;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'd0);
            end else begin
                check("instr", 64'(out_instr), 64'(sb[0].ei));
                check("err", 64'(out_err), 64'(sb[0].ee));
                check("addr", 64'(out_addr), 64'(exp_addr));
                if (out_ready) begin
                    void'(sb.pop_front());
                    exp_addr = exp_addr + 4'd4;
                end
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(stim_q.pop_front());
        end
    endtask

    task automatic drain();
        ordy = 1'b1;
        for (int i = 0; i < 200 && (stim_q.size() != 0 || sb.size() != 0); i++) step();
        check("drain_left", 64'(stim_q.size() + sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        stim_q.delete();
        sb.delete();
        exp_addr = '0;
    endtask

    initial begin
        logic [31:0] r;
        logic [1:0]  mode;
        stim_t       s;
        in_valid = 1'b0;
        #12 reset = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);

        add(3'd1, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 1'b0);
        drain();

        do_reset();
        add(3'd2, 5'd0, 5'd2, 5'd7, 3'd2, 7'd0, 32'd8, 32'h0071_2423, 1'b0);
        add(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        drain();

        // Backpressure: third bundle must be held while the FIFO is full.
        do_reset();
        ordy = 1'b0;
        add(3'd4, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 32'h4052_01B3, 1'b0);
        add(3'd0, 5'd9, 5'd1, 5'd0, 3'd2, 7'd0, 32'd16, 32'h0100_A483, 1'b0);
        add(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_8093, 1'b0);
        repeat (4) step();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_held", 64'(stim_q.size()), 64'd1);
        ordy = 1'b1;
        step();
        check("full_ignores_out_ready", 64'(in_ready), 64'd0);
        drain();

        // Error cases; the expected flag depends on whether the range check is built in.
        add(3'd6, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'd5, 32'h0000_0013, 1'b1);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
        add(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1);
        add(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1);
`else
        add(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b0);
        add(3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b0);
`endif
        drain();

        // Random traffic with random backpressure; addresses wrap every 4 words.
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            mode = 2'($urandom_range(0, 3));
            s.op = 3'($urandom_range(0, 7)); s.rd = 5'($urandom); s.rs1 = 5'($urandom);
            s.rs2 = 5'($urandom); s.f3 = 3'($urandom); s.f7 = 7'($urandom);
            s.imm = (mode == 2'd0) ? r : (mode == 2'd1) ? {{20{r[11]}}, r[11:0]} : {{19{r[12]}}, r[12:1], 1'b0};
            s = model(s);
            stim_q.push_back(s);
            if (($urandom & 32'd3) == 32'd0) step();
        end
        for (int i = 0; i < 400 && (stim_q.size() != 0 || sb.size() != 0); i++) step();
        check("rand_left", 64'(stim_q.size() + sb.size()), 64'd0);
        rnd_ready = 1'b0;

        // Asynchronous reset while two words are buffered.
        ordy = 1'b0;
        add(3'd4, 5'd1, 5'd2, 5'd3, 3'd7, 7'd0, 32'd0, 32'h0031_70B3, 1'b0);
        add(3'd1, 5'd4, 5'd4, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0072_0213, 1'b0);
        repeat (3) step();
        check("pre_rst_full", 64'(in_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_addr", 64'(out_addr), 64'd0);
        check("arst_instr", 64'(out_instr), 64'd0);
        stim_q.delete();
        sb.delete();
        exp_addr = '0;
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
